z80_relbranch_seq: RTL and testbench



---
 rtl/z80_relbranch_seq_pkg.sv | 35 +++
 rtl/z80_relbranch_seq_target.sv | 20 ++
 rtl/z80_relbranch_seq.sv | 140 ++++++++++++++
 tb/tb_z80_relbranch_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/z80_relbranch_seq_pkg.sv
// Shared encodings for the relative-branch sequencer (DJNZ e, JR e, JR cc,e).
// Holds the instruction-select codes, the M-cycle type codes reported to the
// z80fi checker, and the FSM / read-phase state types.
package z80_relbranch_seq_pkg;

  // M-cycle type codes (CYCLE_NONE is what an idle sequencer reports)
  localparam logic [2:0] CYCLE_NONE     = 3'd0;
  localparam logic [2:0] CYCLE_RDWR_MEM = 3'd1;
  localparam logic [2:0] CYCLE_INTERNAL = 3'd2;
  localparam logic [2:0] CYCLE_EXTENDED = 3'd3;

  // Instruction select
  localparam logic [1:0] RB_OP_JR   = 2'b00;
  localparam logic [1:0] RB_OP_JRCC = 2'b01;
  localparam logic [1:0] RB_OP_DJNZ = 2'b10;
  localparam logic [1:0] RB_OP_ILL  = 2'b11;

  // Length of the internal M-cycle that follows a taken branch
  localparam logic [7:0] INT_T = 8'd5;

  typedef enum logic [1:0] {
    RB_IDLE = 2'd0,
    RB_EXT  = 2'd1,
    RB_RD   = 2'd2,
    RB_INT  = 2'd3
  } rb_state_e;

  // Phase inside the displacement read: T1, then T2 and any waits, then T3
  typedef enum logic [1:0] {
    RD_T1  = 2'd0,
    RD_T2W = 2'd1,
    RD_T3  = 2'd2
  } rd_phase_e;

endpackage

// File: rtl/z80_relbranch_seq_target.sv
// Branch target adder: pc_out = pc + 2 + (taken ? sign-extended e : 0),
// wrapping modulo 2^ADDR_W. Purely combinational.
// Ports: pc (opcode address), e (displacement byte), taken, pc_out.
module z80_relbranch_target
  import z80_relbranch_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [7:0]        e,
  input  logic              taken,
  output logic [ADDR_W-1:0] pc_out
);

  logic [ADDR_W-1:0] disp;

  assign disp   = taken ? {{(ADDR_W-8){e[7]}}, e} : '0;
  assign pc_out = pc + ADDR_W'(2) + disp;

endmodule

// File: rtl/z80_relbranch_seq.sv
// Relative-branch sequencer. After the opcode M1 it optionally runs the DJNZ
// M1 extension, reads the displacement byte (with wait states), and runs the
// 5-T internal cycle when the branch is taken. Reports M-cycle type and the
// 1-based T-state index every clock.
// Ports: clk/reset (sync, active-high); start/op/cond/pc_in/cnt_in request;
// mem_req/mem_addr/mem_ack/mem_rdata displacement read; busy/done/illegal
// status; pc_out/cnt_out/cnt_we results; mcycle_type/tcycle trace.
module z80_relbranch_seq
  import z80_relbranch_seq_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned M1_EXT_T = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              cond,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [CNT_W-1:0]  cnt_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_out,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              cnt_we,
  output logic [2:0]        mcycle_type,
  output logic [2:0]        tcycle
);

  localparam logic [7:0] EXT_LAST = 8'(M1_EXT_T);

  rb_state_e         state_q, state_d;
  rd_phase_e         ph_q, ph_d;
  logic [7:0]        tcnt_q, tcnt_d;   // wider than tcycle so long EXT counts work
  logic              is_djnz_q, taken_q;
  logic [ADDR_W-1:0] pc_q, tgt;
  logic              accept, rd_last;

  assign accept  = start && (state_q == RB_IDLE) && (op != RB_OP_ILL);
  assign rd_last = (state_q == RB_RD) && (ph_q == RD_T3);

  z80_relbranch_target #(.ADDR_W(ADDR_W)) u_target (
    .pc     (pc_q),
    .e      (mem_rdata),
    .taken  (taken_q),
    .pc_out (tgt)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    tcnt_d  = tcnt_q + 8'd1;
    unique case (state_q)
      RB_IDLE: begin
        tcnt_d = 8'd1;
        ph_d   = RD_T1;
        if (accept)
          state_d = (op == RB_OP_DJNZ && M1_EXT_T != 0) ? RB_EXT : RB_RD;
      end
      RB_EXT: begin
        if (tcnt_q == EXT_LAST) begin
          state_d = RB_RD;
          tcnt_d  = 8'd1;
        end
      end
      RB_RD: begin
        unique case (ph_q)
          RD_T1:  ph_d = RD_T2W;
          RD_T2W: if (mem_ack) ph_d = RD_T3;  // end of T2 / each TW
          default: begin
            ph_d    = RD_T1;
            tcnt_d  = 8'd1;
            state_d = taken_q ? RB_INT : RB_IDLE;
          end
        endcase
      end
      default: begin
        if (tcnt_q == INT_T) state_d = RB_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != RB_IDLE);
  assign mem_req = (state_q == RB_RD) && (ph_q != RD_T3);
  assign done    = (rd_last && !taken_q) || (state_q == RB_INT && tcnt_q == INT_T);
  assign cnt_we  = done && is_djnz_q;
  assign tcycle  = busy ? tcnt_q[2:0] : 3'd0;

  always_comb begin
    mcycle_type = CYCLE_NONE;
    unique case (state_q)
      RB_EXT:  mcycle_type = CYCLE_EXTENDED;
      RB_RD:   mcycle_type = CYCLE_RDWR_MEM;
      RB_INT:  mcycle_type = CYCLE_INTERNAL;
      default: mcycle_type = CYCLE_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RB_IDLE;
      ph_q      <= RD_T1;
      tcnt_q    <= '0;
      is_djnz_q <= 1'b0;
      taken_q   <= 1'b0;
      pc_q      <= '0;
      mem_addr  <= '0;
      pc_out    <= '0;
      cnt_out   <= '0;
      illegal   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      tcnt_q  <= tcnt_d;
      illegal <= start && (state_q == RB_IDLE) && (op == RB_OP_ILL);
      if (accept) begin
        is_djnz_q <= (op == RB_OP_DJNZ);
        unique case (op)
          RB_OP_JR:   taken_q <= 1'b1;
          RB_OP_JRCC: taken_q <= cond;
          default:    taken_q <= (cnt_in != CNT_W'(1));  // B-1 != 0, 0 wraps
        endcase
        pc_q     <= pc_in;
        mem_addr <= pc_in + ADDR_W'(1);
        // Not-taken target needs no displacement, so it is ready for a
        // done in T3 before the byte is latched.
        pc_out   <= pc_in + ADDR_W'(2);
        cnt_out  <= cnt_in - CNT_W'(1);
      end
      if (rd_last) pc_out <= tgt;
    end
  end

endmodule

// File: tb/tb_z80_relbranch_seq.sv
module tb_z80_relbranch_seq;
  import z80_relbranch_seq_pkg::*;

  logic clk, reset, cond;
  logic start0, start1, ack0, ack1;
  logic [1:0]  op;
  logic [15:0] pc_in, cnt_in;
  logic [7:0]  mem_rdata;

  logic d0_req, d0_busy, d0_done, d0_ill, d0_we;
  logic [15:0] d0_addr, d0_pc;
  logic [7:0]  d0_cnt;
  logic [2:0]  d0_mt, d0_tc;
  logic d1_req, d1_busy, d1_done, d1_ill, d1_we;
  logic [15:0] d1_addr, d1_pc, d1_cnt;
  logic [2:0]  d1_mt, d1_tc;

  int n_chk = 0, n_fail = 0;
  int nwait = 0, seen0 = 0, seen1 = 0;
  bit sel = 0;

  z80_relbranch_seq u_d0 (
    .clk(clk), .reset(reset), .start(start0), .op(op), .cond(cond),
    .pc_in(pc_in), .cnt_in(cnt_in[7:0]), .mem_req(d0_req), .mem_addr(d0_addr),
    .mem_ack(ack0), .mem_rdata(mem_rdata), .busy(d0_busy), .done(d0_done),
    .illegal(d0_ill), .pc_out(d0_pc), .cnt_out(d0_cnt), .cnt_we(d0_we),
    .mcycle_type(d0_mt), .tcycle(d0_tc));

  z80_relbranch_seq #(.CNT_W(16), .M1_EXT_T(0)) u_d1 (
    .clk(clk), .reset(reset), .start(start1), .op(op), .cond(cond),
    .pc_in(pc_in), .cnt_in(cnt_in), .mem_req(d1_req), .mem_addr(d1_addr),
    .mem_ack(ack1), .mem_rdata(mem_rdata), .busy(d1_busy), .done(d1_done),
    .illegal(d1_ill), .pc_out(d1_pc), .cnt_out(d1_cnt), .cnt_we(d1_we),
    .mcycle_type(d1_mt), .tcycle(d1_tc));

  initial clk = 0;
  always #5 clk = ~clk;

  // Memory: the j-th consecutive cycle of mem_req acks once j >= 2 + nwait
  always @(posedge clk) seen0 <= d0_req ? seen0 + 1 : 0;
  always @(posedge clk) seen1 <= d1_req ? seen1 + 1 : 0;
  assign ack0 = d0_req && ((seen0 + 1) >= (2 + nwait));
  assign ack1 = d1_req && ((seen1 + 1) >= (2 + nwait));

  logic o_req, o_busy, o_done, o_ill, o_we;
  logic [15:0] o_addr, o_pc, o_cnt;
  logic [2:0] o_mt, o_tc;
  always_comb begin
    o_req  = sel ? d1_req  : d0_req;
    o_busy = sel ? d1_busy : d0_busy;
    o_done = sel ? d1_done : d0_done;
    o_ill  = sel ? d1_ill  : d0_ill;
    o_we   = sel ? d1_we   : d0_we;
    o_addr = sel ? d1_addr : d0_addr;
    o_pc   = sel ? d1_pc   : d0_pc;
    o_cnt  = sel ? d1_cnt  : {8'h00, d0_cnt};
    o_mt   = sel ? d1_mt   : d0_mt;
    o_tc   = sel ? d1_tc   : d0_tc;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".busy"}, 32'(o_busy), 32'd0);
    chk({tag, ".done"}, 32'(o_done), 32'd0);
    chk({tag, ".we"},   32'(o_we),   32'd0);
    chk({tag, ".ill"},  32'(o_ill),  32'd0);
    chk({tag, ".req"},  32'(o_req),  32'd0);
    chk({tag, ".mt"},   32'(o_mt),   32'(CYCLE_NONE));
    chk({tag, ".tc"},   32'(o_tc),   32'd0);
    chk({tag, ".pc"},   32'(o_pc),   32'd0);
    chk({tag, ".cnt"},  32'(o_cnt),  32'd0);
    chk({tag, ".addr"}, 32'(o_addr), 32'd0);
  endtask

  // Drive one instruction at a negedge and follow it T-state by T-state.
  task automatic run(input bit s, input logic [1:0] o, input bit c,
                     input logic [15:0] pc, input logic [15:0] cn,
                     input logic [7:0] e, input int nw, input bit poke,
                     input bit rst_int);
    logic [2:0] et[$];
    logic [2:0] ec[$];
    logic [15:0] cmask, se, epc, ecnt;
    bit djnz, tk, ereq;
    int ext, len;
    djnz  = (o == RB_OP_DJNZ);
    ext   = (djnz && !s) ? 1 : 0;
    cmask = s ? 16'hFFFF : 16'h00FF;
    cn    = cn & cmask;
    tk    = (o == RB_OP_JR) || (o == RB_OP_JRCC && c) || (djnz && cn != 16'd1);
    se    = {{8{e[7]}}, e};
    epc   = pc + 16'd2 + (tk ? se : 16'd0);
    ecnt  = (cn - 16'd1) & cmask;
    for (int i = 1; i <= ext; i++) begin et.push_back(CYCLE_EXTENDED); ec.push_back(3'(i)); end
    for (int i = 1; i <= 3 + nw; i++) begin et.push_back(CYCLE_RDWR_MEM); ec.push_back(3'(i)); end
    if (tk) for (int i = 1; i <= 5; i++) begin et.push_back(CYCLE_INTERNAL); ec.push_back(3'(i)); end
    len = et.size();

    sel = s; nwait = nw; op = o; cond = c; pc_in = pc; cnt_in = cn; mem_rdata = e;
    if (s) start1 = 1; else start0 = 1;
    @(negedge clk);
    start0 = 0; start1 = 0;
    for (int cyc = 0; cyc < len; cyc++) begin
      if (poke && cyc == 1) begin
        op = 2'($urandom_range(0, 3)); cond = 1'($urandom); pc_in = 16'($urandom);
        cnt_in = 16'($urandom);
        if (s) start1 = 1; else start0 = 1;
      end
      if (poke && cyc == 2) begin start0 = 0; start1 = 0; end
      ereq = (et[cyc] == CYCLE_RDWR_MEM) && (int'(ec[cyc]) < 3 + nw);
      chk("mtype",  32'(o_mt),   32'(et[cyc]));
      chk("tcycle", 32'(o_tc),   32'(ec[cyc]));
      chk("busy",   32'(o_busy), 32'd1);
      chk("done",   32'(o_done), 32'(cyc == len - 1));
      chk("cnt_we", 32'(o_we),   32'(cyc == len - 1 && djnz));
      chk("illegal", 32'(o_ill), 32'd0);
      chk("mem_req", 32'(o_req), 32'(ereq));
      if (ereq) chk("mem_addr", 32'(o_addr), 32'(pc + 16'd1));
      if (cyc == len - 1) begin
        chk("pc_out",  32'(o_pc),  32'(epc));
        chk("cnt_out", 32'(o_cnt), 32'(ecnt));
      end
      if (rst_int && et[cyc] == CYCLE_INTERNAL && ec[cyc] == 3'd2) begin
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk_idle_zero("rst_mid");
        @(negedge clk);
        chk("rst_mid.done2", 32'(o_done), 32'd0);
        chk("rst_mid.we2",   32'(o_we),   32'd0);
        chk("rst_mid.busy2", 32'(o_busy), 32'd0);
        return;
      end
      @(negedge clk);
    end
    chk("after.busy", 32'(o_busy), 32'd0);
    chk("after.done", 32'(o_done), 32'd0);
    chk("after.mt",   32'(o_mt),   32'(CYCLE_NONE));
    chk("after.tc",   32'(o_tc),   32'd0);
  endtask

  initial begin
    logic [15:0] rc;
    int r;
    reset = 1; start0 = 0; start1 = 0; op = 0; cond = 0;
    pc_in = 0; cnt_in = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk_idle_zero("reset0");
    sel = 1;
    chk_idle_zero("reset1");
    reset = 0;
    sel = 0;
    @(negedge clk);

    run(0, RB_OP_DJNZ, 0, 16'h1000, 16'd5,  8'hFE, 0, 0, 0);
    run(0, RB_OP_DJNZ, 0, 16'h2345, 16'd1,  8'h10, 0, 0, 0);
    run(0, RB_OP_JRCC, 0, 16'h4000, 16'h33, 8'h20, 2, 0, 0);
    run(0, RB_OP_JRCC, 1, 16'hFFF0, 16'h00, 8'h7F, 0, 0, 0);
    run(0, RB_OP_JR,   0, 16'h0005, 16'h00, 8'h80, 1, 0, 0);
    run(1, RB_OP_DJNZ, 0, 16'h0100, 16'h0000, 8'h80, 0, 0, 0);
    run(1, RB_OP_DJNZ, 0, 16'h0200, 16'h0001, 8'h04, 0, 0, 0);

    sel = 0;
    run(0, RB_OP_DJNZ, 0, 16'h5000, 16'd7, 8'h05, 0, 0, 1);
    run(0, RB_OP_JR,   0, 16'h6000, 16'd0, 8'h10, 0, 0, 0);

    // Illegal op: one-cycle pulse, sequencer stays idle
    op = RB_OP_ILL; start0 = 1;
    @(negedge clk);
    start0 = 0;
    chk("ill.pulse", 32'(o_ill),  32'd1);
    chk("ill.busy",  32'(o_busy), 32'd0);
    chk("ill.done",  32'(o_done), 32'd0);
    chk("ill.we",    32'(o_we),   32'd0);
    chk("ill.mt",    32'(o_mt),   32'(CYCLE_NONE));
    @(negedge clk);
    chk("ill.clear", 32'(o_ill),  32'd0);
    chk("ill.busy2", 32'(o_busy), 32'd0);

    // start while busy must not disturb the running instruction
    run(0, RB_OP_DJNZ, 0, 16'h1234, 16'd3, 8'hF0, 1, 1, 0);
    run(0, RB_OP_JRCC, 1, 16'h8000, 16'd0, 8'h81, 0, 1, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 3);
      rc = (r == 0) ? 16'd0 : (r == 1) ? 16'd1 : 16'($urandom);
      run(i >= 28, 2'($urandom_range(0, 2)), 1'($urandom), 16'($urandom), rc,
          8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
